// File: rtl/pink_isa_pkg.sv
// Shared definitions for the 16-bit Pink ISA.
//
// Holds the opcode constants, the op-class membership functions (also used
// by immediate_generator users), the reserved error word and the pure
// encode_instr() function that packs {op, imm, aux} into an instruction word
// with exactly the bit placement the immediate generator decodes.
//
// No ports (package).

package pink_isa_pkg;

    localparam int INSTR_W = 16;
    localparam int OP_W    = 5;
    localparam int IMM_W   = 16;
    localparam int AUX_W   = 4;

    // Word emitted for any illegal request; its low five bits decode as op 7.
    localparam logic [INSTR_W-1:0] ERR_WORD = 16'hFFE7;

    localparam logic [OP_W-1:0] OP_ILLEGAL  = 5'd7;
    localparam logic [OP_W-1:0] OP_B_FIRST  = 5'd16;
    localparam logic [OP_W-1:0] OP_B_LAST   = 5'd19;
    localparam logic [OP_W-1:0] OP_JAL      = 5'd20;
    localparam logic [OP_W-1:0] OP_MOVESP   = 5'd25;
    localparam logic [OP_W-1:0] OP_INPUT    = 5'd26;
    localparam logic [OP_W-1:0] OP_LUI      = 5'd27;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_B,
        CLS_J,
        CLS_LUI,
        CLS_MOVESP,
        CLS_ILLEGAL
    } op_class_e;

    function automatic logic is_r_op(logic [OP_W-1:0] op);
        return (op <= 5'd5) || (op == 5'd15) || (op == 5'd21) || (op == 5'd22);
    endfunction

    function automatic logic is_i_op(logic [OP_W-1:0] op);
        return (op == 5'd6) || ((op >= 5'd8) && (op <= 5'd14)) ||
               (op == 5'd23) || (op == 5'd24);
    endfunction

    function automatic logic is_b_op(logic [OP_W-1:0] op);
        return (op >= OP_B_FIRST) && (op <= OP_B_LAST);
    endfunction

    function automatic logic is_j_op(logic [OP_W-1:0] op);
        return op == OP_JAL;
    endfunction

    function automatic logic is_movesp_op(logic [OP_W-1:0] op);
        return (op == OP_MOVESP) || (op == OP_INPUT);
    endfunction

    function automatic logic is_lui_op(logic [OP_W-1:0] op);
        return op == OP_LUI;
    endfunction

    function automatic op_class_e op_class(logic [OP_W-1:0] op);
        op_class_e cls;
        cls = CLS_ILLEGAL;
        if (is_r_op(op))           cls = CLS_R;
        else if (is_i_op(op))      cls = CLS_I;
        else if (is_b_op(op))      cls = CLS_B;
        else if (is_j_op(op))      cls = CLS_J;
        else if (is_movesp_op(op)) cls = CLS_MOVESP;
        else if (is_lui_op(op))    cls = CLS_LUI;
        return cls;
    endfunction

    // True when imm[15:lsb] are all equal, i.e. the value is representable
    // as a sign-extended (lsb+1)-bit quantity.
    function automatic logic upper_uniform(logic [IMM_W-1:0] imm, int lsb);
        logic u;
        u = 1'b1;
        for (int i = 0; i < IMM_W; i++) begin
            if ((i >= lsb) && (imm[i] != imm[IMM_W-1])) begin
                u = 1'b0;
            end
        end
        return u;
    endfunction

    // Returns {err, instr}. Any illegal op or out-of-range immediate yields
    // {1'b1, ERR_WORD}.
    function automatic logic [INSTR_W:0] encode_instr(logic [OP_W-1:0]  op,
                                                      logic [IMM_W-1:0] imm,
                                                      logic [AUX_W-1:0] aux);
        logic               ok;
        logic [INSTR_W-1:0] w;
        ok = 1'b0;
        w  = ERR_WORD;
        case (op_class(op))
            CLS_R: begin
                ok = (imm[15:9] == 7'd0);
                w  = {imm[8:0], aux[1:0], op};
            end
            CLS_I: begin
                ok = upper_uniform(imm, 8);
                w  = {imm[15], imm[7:0], aux[1:0], op};
            end
            CLS_B: begin
                ok = ~imm[0] & upper_uniform(imm, 7);
                w  = {imm[7:1], aux, op};
            end
            CLS_J: begin
                ok = ~imm[0] & upper_uniform(imm, 11);
                w  = {imm[15], imm[10:1], op};
            end
            CLS_MOVESP: begin
                ok = upper_uniform(imm, 10);
                w  = {imm[15], imm[9:0], op};
            end
            CLS_LUI: begin
                ok = (imm[4:0] == 5'd0);
                w  = {imm[15:5], op};
            end
            default: begin
                ok = 1'b0;
                w  = ERR_WORD;
            end
        endcase
        if (!ok) begin
            return {1'b1, ERR_WORD};
        end
        return {1'b0, w};
    endfunction

endpackage

// File: rtl/instr_word_buffer.sv
// Two-entry FIFO for encoded words ({err, instr}, 17 bits).
//
// Ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   push_valid/push_ready write handshake; push_ready = occupancy < 2
//   push_data             word to store
//   pop_valid/pop_ready   read handshake; pop_valid = occupancy > 0
//   pop_data              head word, straight from storage registers
//
// push_ready and pop_valid come only from the registered count, so there is
// no combinational path from pop_ready to push_ready or from push to pop.

module instr_word_buffer
    import pink_isa_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [INSTR_W:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [INSTR_W:0] pop_data
);

    logic [INSTR_W:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign push_ready = (count != 2'd2);
    assign pop_valid  = (count != 2'd0);
    assign do_push    = push_valid & push_ready;
    assign do_pop     = pop_valid & pop_ready;
    assign pop_data   = mem[rd_ptr];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder for the 16-bit Pink ISA.
//
// Packs {in_op, in_imm, in_aux} into a 16-bit word, range-checks the
// immediate and flags illegal words, then queues {instr, err} in a two-entry
// buffer towards instruction-memory write logic.
//
// Ports:
//   CLK, RESET_N            clock, asynchronous active-low reset
//   in_valid/in_ready       request handshake; in_ready = occupancy < 2
//   in_op, in_imm, in_aux   opcode, decoded immediate value, aux field bits
//   out_valid/out_ready     output handshake for the head word
//   out_instr, out_err      head word and its error flag
//   err_clr, err_sticky     sticky error flag and its clear (set wins)
//   word_count              accepted-request count, wraps at 16 bits
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. A producer holds its payload stable while valid is high and
// ready is low; ready never depends combinationally on the other side's
// valid or ready. Outputs come only from registers.

module instr_encoder
    import pink_isa_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [IMM_W-1:0]   in_imm,
    input  logic [AUX_W-1:0]   in_aux,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic               out_err,
    input  logic               err_clr,
    output logic               err_sticky,
    output logic [15:0]        word_count
);

    logic [INSTR_W:0] enc_word;
    logic [INSTR_W:0] head_word;
    logic             accept;

    assign enc_word = encode_instr(in_op, in_imm, in_aux);
    assign accept   = in_valid & in_ready;

    instr_word_buffer u_buf (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (enc_word),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (head_word)
    );

    assign out_instr = head_word[INSTR_W-1:0];
    assign out_err   = head_word[INSTR_W];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            word_count <= 16'd0;
            err_sticky <= 1'b0;
        end else begin
            if (accept) begin
                word_count <= word_count + 16'd1;
            end
            // A new error in the same cycle as a clear must not be lost.
            if (accept && enc_word[INSTR_W]) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming instruction encoder for the 16-bit Pink ISA. It packs an opcode, an immediate value and auxiliary field bits into a 16-bit instruction word using exactly the bit placement that the immediate generator decodes. Every immediate is range-checked and illegal words are flagged. The block sits between the assembler/loader front end and instruction-memory write logic, with valid/ready handshakes on both sides and a 2-entry output buffer.

## Interface
- No parameters.
- CLK  in  1  rising-edge clock
- RESET_N  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept (buffer occupancy < 2)
- in_op  in  5  opcode, placed at instr[4:0]
- in_imm  in  16  desired decoded immediate value
- in_aux  in  4  non-immediate field bits
- out_valid  out  1  head word valid
- out_ready  in  1  consumer accepts head word
- out_instr  out  16  encoded word
- out_err  out  1  head word is an error word
- err_clr  in  1  clears err_sticky
- err_sticky  out  1  set when any error word is accepted
- word_count  out  16  number of accepted requests, wraps 0xFFFF→0

## Operation
- Accept on in_valid & in_ready. Encode combinationally, then push {instr, err} into the buffer.
- Encoding by op class (instr[4:0] = in_op always on a legal word):
  - R (op ≤5, 15, 21, 22): legal iff imm[15:9]==0. instr[15:7]=imm[8:0], instr[6:5]=aux[1:0].
  - I (6, 8–14, 23, 24): legal iff imm[15:8] is all 0 or all 1. instr[15]=imm[15], instr[14:7]=imm[7:0], instr[6:5]=aux[1:0].
  - B (16–19): legal iff imm[0]==0 and imm[15:7] is uniform. instr[15:9]=imm[7:1], instr[8:5]=aux[3:0].
  - jal (20): legal iff imm[0]==0 and imm[15:11] is uniform. instr[15]=imm[15], instr[14:5]=imm[10:1].
  - movesp/input (25, 26): legal iff imm[15:10] is uniform. instr[15]=imm[15], instr[14:5]=imm[9:0].
  - lui (27): legal iff imm[4:0]==0. instr[15:5]=imm[15:5].
  - The lui, jal and movesp/input classes ignore aux.
- Illegal op (7, 28–31) or range violation: out_instr=16'hFFE7 (decodes as op 7), out_err=1.
- err_sticky: set on acceptance of an error word, cleared by err_clr. If set and clear occur in the same cycle, set wins.
- word_count increments on every acceptance, including error words.

## Timing
- Reset values: out_valid=0, out_instr=0, out_err=0, err_sticky=0, word_count=0, in_ready=1. Buffer is emptied.
- Latency: a request accepted at edge N is visible on out_valid/out_instr after edge N. There is no combinational path from input to output.
- in_ready depends only on registered occupancy. There is no combinational path from out_ready to in_ready.
- Pop on out_valid & out_ready. Push and pop in the same cycle leaves occupancy unchanged, so full throughput is sustained with out_ready held high.
- When occupancy is 2, in_ready=0 and no push occurs. Words leave in FIFO order.
- out_instr and out_err hold steady while out_valid=1 and out_ready=0.
- RESET_N asserted mid-operation discards buffered words immediately, without waiting for a clock edge.

## Structure
- Shared package `pink_isa_pkg` holds:
  - opcode constants and class-membership functions (R/I/B/J/lui/movesp), shared with immediate_generator users;
  - ERR_WORD = 16'hFFE7;
  - a pure `encode_instr(op, imm, aux)` function returning {err, instr}.
- One sub-module: `instr_word_buffer`, a 2-entry 17-bit FIFO with valid/ready ports and registered occupancy.

## Test plan
- I-type: op 8, imm 16'hFFF0, aux 0 → out_instr 16'hF808, out_err 0. Then op 8, imm 16'h0100 → 16'hFFE7, out_err 1, err_sticky 1.
- Branch and jal:
  - op 16, imm 16'hFFFC → 16'hFC10.
  - op 16, imm 16'h0003 (odd) → 16'hFFE7, err.
  - op 20, imm 16'h07FE → 16'h7FF4.
- R and lui:
  - op 3, imm 16'h01FF, aux 4'h2 → 16'hFFC3.
  - op 27, imm 16'h1220 → 16'h123B.
  - op 27, imm 16'h1234 → err.
  - op 30 → err.
- Backpressure: out_ready=0, offer 3 words → exactly 2 accepted and in_ready=0. Raise out_ready → words drain in order, third is accepted, word_count=3.
- Throughput and wrap: out_ready=1, stream 20 back-to-back words from word_count=16'hFFF8 → one output per cycle and word_count ends at 12. Assert err_clr in the same cycle as an error word → err_sticky stays 1.
- Reset mid-stream: with 2 words buffered, drop RESET_N between edges → out_valid=0, word_count=0, err_sticky=0 immediately. After release, the first new word appears 1 cycle after acceptance.
